c2h_axis_frame_buf: RTL and testbench

- Store-and-forward AXI-Stream frame buffer on the card-to-host (C2H) path.
- Sits between the UDP/CMAC receive stream and the XDMA C2H stream input.
- Accepts beats from the CMAC/UDP side without backpressure and releases only complete, error-free frames to XDMA.
- Frames marked bad, or that overflow the buffer, are discarded whole and counted.

---
 rtl/c2h_axis_frame_buf.sv | 210 +++++++++++++++++++++
 tb/tb_c2h_axis_frame_buf.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_axis_frame_buf.sv
// Store-and-forward AXI-Stream frame buffer for the C2H path.
// Only complete, error-free frames are released to XDMA. Bad or overflowing frames are dropped whole.
module c2h_axis_frame_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      xdma_clk,
    input  logic                      xdma_reset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [CNT_WIDTH-1:0]      frame_cnt,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          mem [DEPTH];
    logic [PW-1:0]          wr_cur_q, wr_cur_d;
    logic [PW-1:0]          wr_commit_q, wr_commit_d;
    logic [PW-1:0]          rd_q, rd_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]          level_q;
    logic                   tready_q;
    logic                   m_tvalid_q;
    logic [DATA_WIDTH-1:0]  m_tdata_q;
    logic [KEEP_WIDTH-1:0]  m_tkeep_q;
    logic                   m_tlast_q;
    logic                   full_s;
    logic                   err_now_s;
    logic                   mem_we_s;
    logic                   rd_load_s;

    // Fullness uses the registered read pointer, so a same-cycle read frees nothing yet.
    assign full_s    = (wr_cur_q - rd_q) == PW'(DEPTH);
    assign err_now_s = err_q | s_axis_tuser[0];
    assign rd_load_s = (!m_tvalid_q || m_axis_tready) && (rd_q != wr_commit_q);
    assign rd_d      = rd_load_s ? (rd_q + PW'(1)) : rd_q;

    // Write FSM state register.
    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end else if (full_s) begin
                        state_d = DROP;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write FSM outputs: memory write, pointer commit/rollback and statistics.
    always_comb begin
        wr_cur_d    = wr_cur_q;
        wr_commit_d = wr_commit_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we_s    = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                if (s_axis_tvalid) begin
                    if (full_s) begin
                        wr_cur_d = wr_commit_q;
                        err_d    = 1'b0;
                        if (s_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            drop_cnt_d = drop_cnt_q;
                        end
                    end else begin
                        mem_we_s = 1'b1;
                        wr_cur_d = wr_cur_q + PW'(1);
                        if (s_axis_tlast) begin
                            err_d = 1'b0;
                            if (err_now_s) begin
                                wr_cur_d   = wr_commit_q;
                                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                            end else begin
                                wr_commit_d = wr_cur_q + PW'(1);
                                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            err_d = err_now_s;
                        end
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            DROP: begin
                err_d = 1'b0;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end
            default: begin
                wr_cur_d = wr_commit_q;
                err_d    = 1'b0;
            end
        endcase
    end

    // Frame storage: synchronous write, asynchronous read; contents need no reset.
    always_ff @(posedge xdma_clk) begin
        if (mem_we_s) begin
            mem[wr_cur_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Write-side pointers, counters, occupancy and input ready.
    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            wr_cur_q    <= '0;
            wr_commit_q <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            level_q     <= '0;
            tready_q    <= 1'b0;
        end else begin
            wr_cur_q    <= wr_cur_d;
            wr_commit_q <= wr_commit_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            level_q     <= wr_cur_d - rd_d;
            tready_q    <= 1'b1;
        end
    end

    // Output register and read pointer; only committed beats are ever loaded.
    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            rd_q       <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (rd_load_s) begin
            rd_q       <= rd_d;
            m_tvalid_q <= 1'b1;
            {m_tlast_q, m_tkeep_q, m_tdata_q} <= mem[rd_q[AW-1:0]];
        end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
        end else begin
            m_tvalid_q <= m_tvalid_q;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign level         = level_q;

endmodule

// File: tb/tb_c2h_axis_frame_buf.sv
// Directed bench for c2h_axis_frame_buf (DEPTH=16, 32-bit data).
// Output beats are captured into a queue and compared against bench-built expectations.
module tb_c2h_axis_frame_buf;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int DEPTH = 16;
    localparam int CW = 32;
    localparam int LW = 5;
    localparam int BW = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic [0:0]    s_tuser = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic [LW-1:0] level;

    int vectors = 0;
    int miscompares = 0;
    bit rand_rdy = 1'b0;

    logic [BW-1:0] out_q[$];
    logic [BW-1:0] exp_q[$];
    int            stall_err = 0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat = '0;

    c2h_axis_frame_buf #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .xdma_clk(clk), .xdma_reset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    // Capture accepted output beats and flag any change while stalled.
    always @(posedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || {m_tlast, m_tkeep, m_tdata} != prev_beat))
                stall_err <= stall_err + 1;
            if (m_tvalid && m_tready)
                out_q.push_back({m_tlast, m_tkeep, m_tdata});
            prev_stall <= m_tvalid && !m_tready;
            prev_beat  <= {m_tlast, m_tkeep, m_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                        input logic user);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = last;
        s_tuser  = user;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 2000 && out_q.size() < n; i++) tick();
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        rand_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_tready = 1'b0;
        tick();
        tick();
        vectors++;
        if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %0b, expected 0", s_tready); end
        vectors++;
        if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_m_axis: got %0h, expected 0", {m_tvalid, m_tlast, m_tkeep, m_tdata});
        end
        vectors++;
        if (frame_cnt !== '0 || drop_cnt !== '0 || level !== '0) begin
            miscompares++;
            $display("FAIL reset_stats: got frame=%0d drop=%0d level=%0d, expected 0/0/0", frame_cnt, drop_cnt, level);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (s_tready !== 1'b1) begin miscompares++; $display("FAIL release_tready: got %0b, expected 1", s_tready); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = out_q.size();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({(i % 4) == 3, 4'hF, DW'(i)});
            send(DW'(i), 4'hF, (i % 4) == 3, 1'b0);
            if (i == 3) begin
                vectors++;
                if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL latency_t1: got tvalid=%0b, expected 0", m_tvalid); end
            end
            if (i == 4) begin
                vectors++;
                if (m_tvalid !== 1'b1 || m_tdata !== 32'd0) begin
                    miscompares++;
                    $display("FAIL latency_t2: got tvalid=%0b data=%0h, expected 1/0", m_tvalid, m_tdata);
                end
            end
        end
        drain(base + 12);
        vectors++;
        if (out_q.size() - base !== 12) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d, expected 12", out_q.size() - base);
        end else begin
            for (int i = 0; i < 12; i++) begin
                vectors++;
                if (out_q[base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL b2b_beat%0d: got %0h, expected %0h", i, out_q[base+i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (frame_cnt !== 32'd3 || drop_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL b2b_cnt: got frame=%0d drop=%0d, expected 3/0", frame_cnt, drop_cnt);
        end
    endtask

    task automatic test_bad_frame();
        int base;
        do_reset();
        base = out_q.size();
        send(32'd100, 4'hF, 1'b0, 1'b0);
        send(32'd101, 4'hF, 1'b0, 1'b1);
        send(32'd102, 4'hF, 1'b1, 1'b0);
        send(32'd200, 4'h3, 1'b0, 1'b0);
        send(32'd201, 4'h1, 1'b1, 1'b0);
        drain(base + 2);
        vectors++;
        if (out_q.size() - base !== 2) begin
            miscompares++;
            $display("FAIL bad_count: got %0d, expected 2", out_q.size() - base);
        end else begin
            vectors++;
            if (out_q[base] !== {1'b0, 4'h3, 32'd200} || out_q[base+1] !== {1'b1, 4'h1, 32'd201}) begin
                miscompares++;
                $display("FAIL bad_beats: got %0h %0h, expected c8-frame", out_q[base], out_q[base+1]);
            end
        end
        vectors++;
        if (frame_cnt !== 32'd1 || drop_cnt !== 32'd1 || level !== 5'd0) begin
            miscompares++;
            $display("FAIL bad_stats: got frame=%0d drop=%0d level=%0d, expected 1/1/0", frame_cnt, drop_cnt, level);
        end
    endtask

    task automatic test_long_drop();
        int base;
        do_reset();
        m_tready = 1'b0;
        base = out_q.size();
        for (int i = 0; i < 20; i++) send(DW'(i), 4'hF, i == 19, 1'b0);
        vectors++;
        if (level !== 5'd0 || drop_cnt !== 32'd1 || frame_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL long_stats: got level=%0d drop=%0d frame=%0d, expected 0/1/0", level, drop_cnt, frame_cnt);
        end
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (m_tvalid !== 1'b0 || out_q.size() != base) begin
            miscompares++;
            $display("FAIL long_tvalid: got tvalid=%0b beats=%0d, expected 0/0", m_tvalid, out_q.size() - base);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        m_tready = 1'b0;
        base = out_q.size();
        exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back({(i % 5) == 4, 4'hF, DW'(300 + i)});
            send(DW'(300 + i), 4'hF, (i % 5) == 4, 1'b0);
        end
        tick();
        // One committed beat has moved into the output register, so memory holds 14.
        vectors++;
        if (level !== 5'd14 || frame_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL ovf_level: got level=%0d frame=%0d, expected 14/3", level, frame_cnt);
        end
        for (int i = 0; i < 5; i++) send(DW'(400 + i), 4'hF, i == 4, 1'b0);
        vectors++;
        if (drop_cnt !== 32'd1 || frame_cnt !== 32'd3 || level !== 5'd14) begin
            miscompares++;
            $display("FAIL ovf_drop: got drop=%0d frame=%0d level=%0d, expected 1/3/14", drop_cnt, frame_cnt, level);
        end
        m_tready = 1'b1;
        drain(base + 15);
        vectors++;
        if (out_q.size() - base !== 15) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d, expected 15", out_q.size() - base);
        end else begin
            for (int i = 0; i < 15; i++) begin
                vectors++;
                if (out_q[base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL ovf_beat%0d: got %0h, expected %0h", i, out_q[base+i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (level !== 5'd0) begin miscompares++; $display("FAIL ovf_empty: got level=%0d, expected 0", level); end
    endtask

    task automatic test_random();
        int base;
        int s0;
        int len;
        int w;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        do_reset();
        base = out_q.size();
        s0 = stall_err;
        exp_q.delete();
        rand_rdy = 1'b1;
        for (int f = 0; f < 200; f++) begin
            for (w = 0; w < 300 && level > 5'd8; w++) tick();
            if (w == 300) begin
                vectors++;
                miscompares++;
                $display("FAIL rand_pace: got level=%0d after 300 cycles, expected <=8", level);
            end
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                k = 4'($urandom);
                exp_q.push_back({b == len - 1, k, d});
                send(d, k, b == len - 1, 1'b0);
            end
        end
        drain(base + exp_q.size());
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        drain(base + exp_q.size());
        vectors++;
        if (out_q.size() - base !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d, expected %0d", out_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (out_q[base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rand_beat%0d: got %0h, expected %0h", i, out_q[base+i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (stall_err !== s0) begin
            miscompares++;
            $display("FAIL rand_stable: got %0d stall changes, expected 0", stall_err - s0);
        end
        vectors++;
        if (frame_cnt !== 32'd200 || drop_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL rand_cnt: got frame=%0d drop=%0d, expected 200/0", frame_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        base = out_q.size();
        send(32'd500, 4'hF, 1'b0, 1'b0);
        send(32'd501, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        send(32'd502, 4'hF, 1'b0, 1'b0);
        vectors++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== '0 || level !== '0 ||
            frame_cnt !== '0 || drop_cnt !== '0) begin
            miscompares++;
            $display("FAIL midrst_values: got tready=%0b tvalid=%0b level=%0d, expected 0/0/0",
                     s_tready, m_tvalid, level);
        end
        rst = 1'b0;
        tick();
        send(32'd600, 4'h7, 1'b0, 1'b0);
        send(32'd601, 4'h1, 1'b1, 1'b0);
        drain(base + 2);
        vectors++;
        if (out_q.size() - base !== 2) begin
            miscompares++;
            $display("FAIL midrst_count: got %0d, expected 2", out_q.size() - base);
        end else begin
            vectors++;
            if (out_q[base] !== {1'b0, 4'h7, 32'd600} || out_q[base+1] !== {1'b1, 4'h1, 32'd601}) begin
                miscompares++;
                $display("FAIL midrst_beats: got %0h %0h, expected 600/601 frame", out_q[base], out_q[base+1]);
            end
        end
        vectors++;
        if (frame_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_cnt: got frame=%0d drop=%0d, expected 1/0", frame_cnt, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bad_frame();
        test_long_drop();
        test_overflow();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
